// File: rtl/pdm_capture_pkg.sv
// Constants shared by the PDM capture path and the ethernet sender that drains it.
// Holds the default divider/FIFO sizing, the byte width and a saturating-increment helper.
package pdm_capture_pkg;

  localparam int PDM_DIV_DEFAULT    = 16;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int BYTE_W             = 8;
  localparam int DROP_W             = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [DROP_W-1:0] drop_t;

  function automatic drop_t sat_inc(input drop_t v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/pdm_capture_if.sv
// Byte stream from the capture FIFO to its consumer.
// Handshake: a byte transfers on every rising clk edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0, out_data and out_valid hold steady.
interface pdm_capture_if;
  import pdm_capture_pkg::*;

  byte_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pdm_capture_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with full/empty flags.
// A write while full is accepted only when a read retires the head on the same edge.
module byte_fifo
  import pdm_capture_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  byte_t wr_data,
  input  logic  rd_en,
  output byte_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_rd;
  logic          do_wr;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pdm_capture.sv
// PDM microphone front end: generates the mic clock, samples on its falling edge,
// packs bits MSB-first into bytes and buffers them, counting bytes lost to a full FIFO.
module pdm_capture
  import pdm_capture_pkg::*;
#(
  parameter int PDM_DIV    = PDM_DIV_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             au_pdm_clk,
  input  logic             au_pdm_data,
  pdm_capture_if.master    stream,
  output logic             overflow,
  output drop_t            drop_count
);

  localparam int CW   = $clog2(PDM_DIV);
  localparam int HALF = PDM_DIV / 2;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]    bit_cnt;
  byte_t         shift;
  logic          sample;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  byte_t         fifo_rd_data;

  always_comb begin
    cnt_next = '0;
    if (enable) cnt_next = (cnt == CW'(PDM_DIV-1)) ? '0 : cnt + CW'(1);
  end

  // Sampling on the HALF-1 -> HALF step coincides with the registered mic clock falling.
  assign sample = enable && (cnt == CW'(HALF-1));
  assign push   = (bit_cnt == 4'd8);
  assign pop    = stream.out_valid && stream.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      au_pdm_clk <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      cnt        <= cnt_next;
      au_pdm_clk <= enable && (cnt_next < CW'(HALF));
      if (push) begin
        bit_cnt <= '0;
      end else if (!enable) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (sample) begin
        shift   <= {shift[BYTE_W-2:0], au_pdm_data};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (push && fifo_full && !pop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shift),
    .rd_en   (stream.out_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign stream.out_valid = !fifo_empty;
  assign stream.out_data  = fifo_rd_data;

endmodule

// File: tb/tb_pdm_capture.sv
// Directed bench for pdm_capture with PDM_DIV=4 and a 16-entry FIFO.
// Popped bytes are collected by a monitor and compared against an expected queue.
module tb_pdm_capture;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       au_pdm_clk;
  logic       au_pdm_data;
  logic       overflow;
  logic [7:0] drop_count;

  int n_cmp;
  int n_fail;
  int got_base;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  pdm_capture_if bus ();

  pdm_capture #(.PDM_DIV(4), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .au_pdm_clk  (au_pdm_clk),
    .au_pdm_data (au_pdm_data),
    .stream      (bus),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Must start right after enable rises (or after another send); each bit spans one PDM period.
  task automatic send_bits(input logic [7:0] b, input int n, input bit pop_at_push);
    for (int k = 1; k <= 4*n; k++) begin
      au_pdm_data = b[7 - (k-1)/4];
      if (pop_at_push && k == 31) bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("pdm_clk", {31'd0, au_pdm_clk}, {31'd0, ((k % 4) < 2)});
      if (pop_at_push && k == 31) bus.out_ready = 1'b0;
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size()) check(tag, {24'd0, got_q[got_base + i]}, {24'd0, exp_q[i]});
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; got_base = 0;
    rst_n = 1'b0; enable = 1'b0; au_pdm_data = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("rst_valid", {31'd0, bus.out_valid}, 0);
    check("rst_data", {24'd0, bus.out_data}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_drop", {24'd0, drop_count}, 0);
    check("rst_pdm_clk", {31'd0, au_pdm_clk}, 0);

    // Single byte 1,0,1,0,0,1,0,1 -> 0xA5 with the consumer always ready.
    bus.out_ready = 1'b1;
    enable = 1'b1;
    send_bits(8'hA5, 8, 1'b0);
    enable = 1'b0;
    cycles(2);
    exp_q.push_back(8'hA5);
    check_stream("t1_byte");
    check("t1_valid_after", {31'd0, bus.out_valid}, 0);

    // 17 bytes into a 16-deep FIFO with no consumer: last one dropped.
    bus.out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i <= 16; i++) send_bits(8'(i), 8, 1'b0);
    enable = 1'b0;
    cycles(2);
    check("t2_overflow", {31'd0, overflow}, 1);
    check("t2_drop", {24'd0, drop_count}, 1);
    check("t2_valid", {31'd0, bus.out_valid}, 1);
    check("t2_head", {24'd0, bus.out_data}, 32'h00);
    bus.out_ready = 1'b1;
    cycles(20);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_stream("t2_drain");
    check("t2_empty", {31'd0, bus.out_valid}, 0);

    // Full FIFO, pop coincides with the push edge: nothing lost.
    bus.out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) send_bits(8'(8'h20 + i), 8, 1'b0);
    check("t3_full_valid", {31'd0, bus.out_valid}, 1);
    send_bits(8'h30, 8, 1'b1);
    enable = 1'b0;
    cycles(2);
    check("t3_drop", {24'd0, drop_count}, 1);
    check("t3_overflow", {31'd0, overflow}, 1);
    check("t3_head", {24'd0, bus.out_data}, 32'h21);
    bus.out_ready = 1'b1;
    cycles(20);
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(8'h20 + i));
    check_stream("t3_order");

    // Enable dropped after 5 bits; partial byte must vanish.
    enable = 1'b1;
    send_bits(8'hF8, 5, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check("t4_pdm_clk_off", {31'd0, au_pdm_clk}, 0);
    end
    check("t4_no_partial", {31'd0, bus.out_valid}, 0);
    enable = 1'b1;
    send_bits(8'h3C, 8, 1'b0);
    enable = 1'b0;
    cycles(2);
    exp_q.push_back(8'h3C);
    check_stream("t4_byte");

    // One-cycle reset mid-byte with three bytes buffered.
    bus.out_ready = 1'b0;
    enable = 1'b1;
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h33, 8, 1'b0);
    send_bits(8'hE0, 3, 1'b0);
    check("t5_valid_before", {31'd0, bus.out_valid}, 1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("t5_valid", {31'd0, bus.out_valid}, 0);
    check("t5_data", {24'd0, bus.out_data}, 0);
    check("t5_overflow", {31'd0, overflow}, 0);
    check("t5_drop", {24'd0, drop_count}, 0);
    check("t5_pdm_clk", {31'd0, au_pdm_clk}, 0);
    bus.out_ready = 1'b1;
    send_bits(8'h5A, 8, 1'b0);
    enable = 1'b0;
    cycles(2);
    exp_q.push_back(8'h5A);
    check_stream("t5_after");

    // 300 drops saturate the counter at 255.
    bus.out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 26; i++) send_bits(8'(8'h40 + i), 8, 1'b0);
    check("t6_drop10", {24'd0, drop_count}, 10);
    for (int i = 26; i < 316; i++) send_bits(8'(8'h40 + i), 8, 1'b0);
    enable = 1'b0;
    cycles(2);
    check("t6_drop_sat", {24'd0, drop_count}, 255);
    check("t6_overflow", {31'd0, overflow}, 1);
    check("t6_head", {24'd0, bus.out_data}, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
